// File: rtl/cluster_unpacker_if.sv
// Cluster-word stream between a packed-cluster source and the unpacker.
// The source drives valid/word/last; the unpacker drives ready.
interface cluster_unpacker_if #(
    parameter int MXADRB = 11,
    parameter int MXCNTB = 3
);
    logic                       clust_valid;
    logic                       clust_ready;
    logic [MXCNTB+MXADRB-1:0]   clust_word;
    logic                       clust_last;

    modport master (
        output clust_valid,
        output clust_word,
        output clust_last,
        input  clust_ready
    );

    modport slave (
        input  clust_valid,
        input  clust_word,
        input  clust_last,
        output clust_ready
    );
endinterface

// File: rtl/cluster_unpacker.sv
// cluster_unpacker: re-expands packed cluster words {count, adr} into runs of
// consecutive S-bits, ORs them into a pad-map accumulator and publishes the map
// for one cycle when the frame-closing word arrives.
// Optional feature macro: CLUSTER_LIMIT_EN -- caps the number of non-null
// clusters merged per frame at MXCLUSTERS and reports the excess on overflow.
module cluster_unpacker #(
    parameter int MXSBITS    = 1536,
    parameter int MXADRB     = 11,
    parameter int MXCNTB     = 3,
    parameter int MXCLUSTERS = 8
) (
    input  logic                clock,
    input  logic                reset,
    cluster_unpacker_if.slave   clust,
    output logic [MXSBITS-1:0]  sbits_out,
    output logic                sbits_valid,
    output logic                overflow
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic [MXSBITS-1:0]   acc_q, acc_d;
    logic [MXSBITS-1:0]   sbits_out_q, sbits_out_d;
    logic                 sbits_valid_q, sbits_valid_d;
    logic                 overflow_q, overflow_d;

    logic                 transfer_s;
    logic [MXADRB-1:0]    adr_s;
    logic [MXCNTB-1:0]    cnt_s;
    logic                 is_null_s;
    logic                 over_s;
    logic                 frame_ovf_s;
    logic [MXSBITS-1:0]   merge_s;

    // Decode (n, a) into a mask with pads a..a+n set; bits past the top are
    // shifted out (clipped), and null addresses give an empty mask.
    function automatic logic [MXSBITS-1:0] expand(input logic [MXCNTB-1:0] n,
                                                  input logic [MXADRB-1:0] a);
        logic [MXSBITS-1:0] run;
        run = '0;
        for (int i = 0; i < (1 << MXCNTB); i++) begin
            if (i <= int'(n)) begin
                run[i] = 1'b1;
            end else begin
                run[i] = 1'b0;
            end
        end
        if (int'(a) < MXSBITS) begin
            expand = run << a;
        end else begin
            expand = '0;
        end
    endfunction

    assign adr_s       = clust.clust_word[MXADRB-1:0];
    assign cnt_s       = clust.clust_word[MXCNTB+MXADRB-1:MXADRB];
    assign is_null_s   = (int'(adr_s) >= MXSBITS);
    assign transfer_s  = clust.clust_valid & ready_q;
    assign clust.clust_ready = ready_q;
    assign sbits_out   = sbits_out_q;
    assign sbits_valid = sbits_valid_q;
    assign overflow    = overflow_q;

`ifdef CLUSTER_LIMIT_EN
    localparam int CNTW = $clog2(MXCLUSTERS + 1);

    logic [CNTW-1:0] ncl_q, ncl_d;
    logic            ovf_sticky_q, ovf_sticky_d;

    // Per-frame count of merged non-null clusters and sticky excess flag.
    always_comb begin
        ncl_d        = ncl_q;
        ovf_sticky_d = ovf_sticky_q;
        over_s       = (!is_null_s) && (int'(ncl_q) >= MXCLUSTERS);
        frame_ovf_s  = ovf_sticky_q | over_s;
        if (transfer_s) begin
            if (clust.clust_last) begin
                ncl_d        = '0;
                ovf_sticky_d = 1'b0;
            end else if (!is_null_s && !over_s) begin
                ncl_d        = ncl_q + CNTW'(1);
                ovf_sticky_d = frame_ovf_s;
            end else begin
                ovf_sticky_d = frame_ovf_s;
            end
        end else begin
            ncl_d        = ncl_q;
        end
    end

    // Cluster limit counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ncl_q        <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            ncl_q        <= ncl_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end
`else
    assign over_s      = 1'b0;
    assign frame_ovf_s = 1'b0;
`endif

    // Frame FSM: merge words into the accumulator, publish the map on close.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        sbits_out_d   = sbits_out_q;
        sbits_valid_d = 1'b0;
        overflow_d    = overflow_q;
        if (transfer_s && !over_s) begin
            merge_s = expand(cnt_s, adr_s);
        end else begin
            merge_s = '0;
        end
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (transfer_s) begin
                    if (clust.clust_last) begin
                        state_d       = ST_FLUSH;
                        sbits_out_d   = acc_q | merge_s;
                        sbits_valid_d = 1'b1;
                        overflow_d    = frame_ovf_s;
                        acc_d         = '0;
                    end else begin
                        state_d       = ST_ACCUM;
                        acc_d         = acc_q | merge_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
            end
        endcase
        ready_d = (state_d != ST_FLUSH);
    end

    // State, accumulator and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b0;
            acc_q         <= '0;
            sbits_out_q   <= '0;
            sbits_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            acc_q         <= acc_d;
            sbits_out_q   <= sbits_out_d;
            sbits_valid_q <= sbits_valid_d;
            overflow_q    <= overflow_d;
        end
    end
endmodule

// File: doc/cluster_unpacker.md
# cluster_unpacker

Inverse of the per-pad cluster counting/packing stage: accepts packed cluster words (3-bit extra-length count plus 11-bit pad address) over a valid/ready stream. It re-expands each word into its run of consecutive S-bits and accumulates them into a 1536-bit pad map. At frame end it emits the map for one cycle. It sits on the receive/monitoring side, next to the cluster packer, and is used for readback and for loopback checking of the packer.

## Interface
- MXSBITS, 1536, number of S-bit pads in the map
- MXADRB, 11, address field width
- MXCNTB, 3, count field width (count n encodes n+1 consecutive pads)
- MXCLUSTERS, 8, maximum non-null clusters per frame (used only with CLUSTER_LIMIT_EN)

- clock  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- clust_valid  in  1  clust_word/clust_last are valid
- clust_ready  out  1  block can accept a word this cycle
- clust_word  in  14  {count[13:11], adr[10:0]}
- clust_last  in  1  sideband; qualified with clust_valid; word closes the frame
- sbits_out  out  MXSBITS  reconstructed pad map of the last closed frame
- sbits_valid  out  1  one-cycle pulse: sbits_out updated
- overflow  out  1  frame exceeded MXCLUSTERS (valid with sbits_valid)

## Operation
- Transfer occurs on a rising clock edge where clust_valid & clust_ready are both 1. Nothing else is sampled.
- Expansion of word (n, a): set pads a .. a+n inclusive. Pads above MXSBITS-1 are clipped, not wrapped.
- Null word: adr >= MXSBITS (e.g. 0x7FF). It contributes no bits and is not counted. With clust_last = 1 it closes an empty frame.
- Accumulator acc[MXSBITS-1:0]: on a transfer, acc <= acc | expand(word). Overlapping clusters OR together.
- State machine:
  - IDLE: clust_ready=1, no transfer yet this frame. A transfer without last moves to ACCUM. A transfer with last moves to FLUSH.
  - ACCUM: clust_ready=1. A transfer with last moves to FLUSH. A transfer without last stays in ACCUM.
  - FLUSH: clust_ready=0 for exactly one cycle, then IDLE.
- Frame close (a transfer with clust_last=1), all on that edge:
  - sbits_out <= acc | expand(word)
  - sbits_valid <= 1
  - overflow <= frame overflow state
  - acc <= 0 and cluster counter <= 0
- sbits_out holds its value until the next frame close. sbits_valid is high for exactly one cycle per closed frame.
- Reset (asynchronous, including mid-frame):
  - acc, sbits_out, sbits_valid, overflow and the counter go to 0.
  - State goes to IDLE; clust_ready=0 while reset is asserted.
  - The partial frame is discarded and produces no sbits_valid.

## Timing
- Latency: sbits_valid and the new sbits_out are visible in the cycle after the closing transfer edge.
- Minimum frame spacing is 2 cycles, because of the FLUSH bubble.
- Sustained throughput is 1 word per cycle within a frame.
- clust_ready is a registered function of state only; it does not depend combinationally on clust_valid.
- Expansion and OR are single-cycle: a 1536-wide decode of (adr, n) into a mask.

## Configuration
- CLUSTER_LIMIT_EN defined:
  - A counter of non-null transfers runs per frame.
  - Non-null words arriving after MXCLUSTERS have already been accepted are still handshaken, but are not ORed into the map. They set a sticky frame overflow.
  - A closing word that itself exceeds the limit is dropped from the map, but still closes the frame.
  - overflow is reported at close.
- CLUSTER_LIMIT_EN undefined:
  - No counter; all words are merged.
  - overflow is tied to 0.

## Test plan
- Reset, then word (n=0, a=5) with last -> next cycle sbits_valid=1, sbits_out has only bit 5 set; clust_ready=0 for one cycle, then 1.
- Words (n=7, a=100) then (n=2, a=105, last) -> pads 100..107 set, nothing else; overflow=0.
- Word (n=7, a=1532) with last -> pads 1532..1535 set, bit 0 clear (no wrap).
- Null word (a=0x7FF) with last, no prior words -> sbits_valid pulse, sbits_out all zeros, previous map replaced.
- With CLUSTER_LIMIT_EN: 9 words at a=0,10,..,80 (n=0), the 9th with last -> pads 0..70 step 10 set, pad 80 clear, overflow=1. Without the macro: pad 80 also set, overflow=0.
- Assert reset after 3 words mid-frame, then release and send (n=1, a=20, last) -> no pulse during reset; then only pads 20,21 set.
